// File: rtl/mempool_bank_arbiter_if.sv
// Request, bank and response bundle for one TCDM bank arbiter.
// The slave modport is the arbiter side; the master modport is the
// requester/bank/consumer environment side.
interface mempool_bank_arbiter_if #(
  parameter int unsigned NumReq        = 4,
  parameter int unsigned BankAddrWidth = 8,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned MetaWidth     = 4
);
  localparam int unsigned BeWidth  = DataWidth / 8;
  localparam int unsigned IdxWidth = $clog2(NumReq);

  logic [NumReq-1:0]                    req_valid_i;
  logic [NumReq-1:0]                    req_ready_o;
  logic [NumReq-1:0][BankAddrWidth-1:0] req_addr_i;
  logic [NumReq-1:0]                    req_wen_i;
  logic [NumReq-1:0][BeWidth-1:0]       req_be_i;
  logic [NumReq-1:0][DataWidth-1:0]     req_wdata_i;
  logic [NumReq-1:0][MetaWidth-1:0]     req_meta_i;

  logic                                 bank_req_o;
  logic                                 bank_we_o;
  logic [BankAddrWidth-1:0]             bank_addr_o;
  logic [BeWidth-1:0]                   bank_be_o;
  logic [DataWidth-1:0]                 bank_wdata_o;
  logic [DataWidth-1:0]                 bank_rdata_i;

  logic                                 resp_valid_o;
  logic                                 resp_ready_i;
  logic [IdxWidth-1:0]                  resp_idx_o;
  logic [DataWidth-1:0]                 resp_rdata_o;
  logic [MetaWidth-1:0]                 resp_meta_o;

  modport slave (
    input  req_valid_i, req_addr_i, req_wen_i, req_be_i, req_wdata_i, req_meta_i,
    input  bank_rdata_i, resp_ready_i,
    output req_ready_o, bank_req_o, bank_we_o, bank_addr_o, bank_be_o, bank_wdata_o,
    output resp_valid_o, resp_idx_o, resp_rdata_o, resp_meta_o
  );

  modport master (
    output req_valid_i, req_addr_i, req_wen_i, req_be_i, req_wdata_i, req_meta_i,
    output bank_rdata_i, resp_ready_i,
    input  req_ready_o, bank_req_o, bank_we_o, bank_addr_o, bank_be_o, bank_wdata_o,
    input  resp_valid_o, resp_idx_o, resp_rdata_o, resp_meta_o
  );
endinterface

// File: rtl/mempool_bank_arbiter.sv
// Round-robin arbiter and sequencer for one TCDM SRAM bank. Reads (and, with
// MEMPOOL_BANK_ARB_WRITE_ACK_EN defined, writes) are tagged, carried through a
// one-entry in-flight stage across the SRAM latency and queued in a small
// credit-protected response FIFO.
module mempool_bank_arbiter #(
  parameter int unsigned NumReq        = 4,
  parameter int unsigned BankAddrWidth = 8,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned MetaWidth     = 4,
  parameter int unsigned RespDepth     = 2
) (
  input logic                   clk_i,
  input logic                   rst_ni,
  mempool_bank_arbiter_if.slave arb_io
);
  localparam int unsigned IdxWidth = $clog2(NumReq);
  localparam int unsigned PtrWidth = (RespDepth > 1) ? $clog2(RespDepth) : 1;
  localparam int unsigned CntWidth = $clog2(RespDepth + 1);

  logic [IdxWidth-1:0]  rr_q, rr_d;
  logic [CntWidth-1:0]  count_q, count_d;
  logic [PtrWidth-1:0]  wr_ptr_q, rd_ptr_q;
  logic [IdxWidth-1:0]  fifo_idx_q  [RespDepth];
  logic [MetaWidth-1:0] fifo_meta_q [RespDepth];
  logic [DataWidth-1:0] fifo_data_q [RespDepth];
  logic                 inflight_q;
  logic [IdxWidth-1:0]  inflight_idx_q;
  logic [MetaWidth-1:0] inflight_meta_q;
`ifdef MEMPOOL_BANK_ARB_WRITE_ACK_EN
  logic                 inflight_wr_q;
`endif

  logic                 push, pop, credit_ok, grant, issue_resp;
  logic [NumReq-1:0]    eligible;
  logic [IdxWidth-1:0]  winner;
  logic [DataWidth-1:0] push_data;
  int unsigned          cand;

  function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
    if (32'(p) == RespDepth - 1) return '0;
    return p + 1'b1;
  endfunction

  assign push                = inflight_q;
  assign arb_io.resp_valid_o = (count_q != '0);
  assign pop                 = arb_io.resp_valid_o & arb_io.resp_ready_i;
  assign count_d             = count_q + CntWidth'(push) - CntWidth'(pop);

  // Credit check: a pop this cycle frees a slot for the access issued now.
  always_comb begin
    credit_ok = (32'(count_q) + 32'(inflight_q) - 32'(pop)) < RespDepth;
`ifdef MEMPOOL_BANK_ARB_WRITE_ACK_EN
    eligible  = arb_io.req_valid_i & {NumReq{credit_ok}};
`else
    eligible  = arb_io.req_valid_i & (arb_io.req_wen_i | {NumReq{credit_ok}});
`endif
  end

  // Round-robin search starting at rr_q; held in reset so nothing is granted.
  always_comb begin
    grant  = 1'b0;
    winner = '0;
    cand   = 0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      cand = (32'(rr_q) + k) % NumReq;
      if (!grant && eligible[IdxWidth'(cand)]) begin
        grant  = 1'b1;
        winner = IdxWidth'(cand);
      end
    end
    grant = grant & rst_ni;
    rr_d  = rr_q;
    if (grant) begin
      if (32'(winner) == NumReq - 1) rr_d = '0;
      else                           rr_d = winner + 1'b1;
    end
  end

  // Grant and bank drive: winner's payload muxed out, zeros when idle.
  always_comb begin
    arb_io.req_ready_o  = '0;
    arb_io.bank_req_o   = 1'b0;
    arb_io.bank_we_o    = 1'b0;
    arb_io.bank_addr_o  = '0;
    arb_io.bank_be_o    = '0;
    arb_io.bank_wdata_o = '0;
    if (grant) begin
      arb_io.req_ready_o[winner] = 1'b1;
      arb_io.bank_req_o          = 1'b1;
      arb_io.bank_we_o           = arb_io.req_wen_i[winner];
      arb_io.bank_addr_o         = arb_io.req_addr_i[winner];
      arb_io.bank_be_o           = arb_io.req_be_i[winner];
      arb_io.bank_wdata_o        = arb_io.req_wdata_i[winner];
    end
  end

  // Which accesses produce a response, and what data they return.
  always_comb begin
`ifdef MEMPOOL_BANK_ARB_WRITE_ACK_EN
    issue_resp = grant;
    push_data  = inflight_wr_q ? '0 : arb_io.bank_rdata_i;
`else
    issue_resp = grant & ~arb_io.req_wen_i[winner];
    push_data  = arb_io.bank_rdata_i;
`endif
  end

  // Control state: pointer, in-flight flag and FIFO bookkeeping.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_q       <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      rr_q       <= rr_d;
      count_q    <= count_d;
      inflight_q <= issue_resp;
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
    end
  end

  // Tag and FIFO payload storage; qualified by the control flags above.
  always_ff @(posedge clk_i) begin
    if (issue_resp) begin
      inflight_idx_q  <= winner;
      inflight_meta_q <= arb_io.req_meta_i[winner];
`ifdef MEMPOOL_BANK_ARB_WRITE_ACK_EN
      inflight_wr_q   <= arb_io.req_wen_i[winner];
`endif
    end
    if (push) begin
      fifo_idx_q[wr_ptr_q]  <= inflight_idx_q;
      fifo_meta_q[wr_ptr_q] <= inflight_meta_q;
      fifo_data_q[wr_ptr_q] <= push_data;
    end
  end

  assign arb_io.resp_idx_o   = fifo_idx_q[rd_ptr_q];
  assign arb_io.resp_meta_o  = fifo_meta_q[rd_ptr_q];
  assign arb_io.resp_rdata_o = fifo_data_q[rd_ptr_q];
endmodule

// File: tb/tb_mempool_bank_arbiter.sv
// Bench for mempool_bank_arbiter: reset check, an arbitration/credit vector
// table, directed multi-cycle sequences and a randomized run against a
// queue-based reference model. Honours MEMPOOL_BANK_ARB_WRITE_ACK_EN.
module tb_mempool_bank_arbiter;
  localparam int unsigned NumReq = 4, BankAddrWidth = 8, DataWidth = 32;
  localparam int unsigned MetaWidth = 4, RespDepth = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mempool_bank_arbiter_if #(
    .NumReq(NumReq), .BankAddrWidth(BankAddrWidth), .DataWidth(DataWidth), .MetaWidth(MetaWidth)
  ) bus ();

  mempool_bank_arbiter #(
    .NumReq(NumReq), .BankAddrWidth(BankAddrWidth), .DataWidth(DataWidth),
    .MetaWidth(MetaWidth), .RespDepth(RespDepth)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .arb_io(bus)
  );

  // SRAM model: one-cycle read latency, byte-enabled writes.
  logic [31:0] sram [256];
  logic [31:0] gold [256];
  logic [31:0] rdata_q = '0;
  always @(posedge clk) begin
    if (bus.bank_req_o) begin
      if (bus.bank_we_o) begin
        for (int b = 0; b < 4; b++)
          if (bus.bank_be_o[b]) sram[bus.bank_addr_o][8*b +: 8] <= bus.bank_wdata_o[8*b +: 8];
      end else begin
        rdata_q <= sram[bus.bank_addr_o];
      end
    end
  end
  assign bus.bank_rdata_i = rdata_q;

  function automatic logic [31:0] init_word(input int i);
    if (i == 18) return 32'hA5A5_1234;
    return 32'h5A00_0000 | (32'(i) * 32'h0001_0203);
  endfunction

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    bus.req_valid_i = '0; bus.req_wen_i = '0; bus.req_addr_i = '0;
    bus.req_be_i = '0; bus.req_wdata_i = '0; bus.req_meta_i = '0;
  endtask

  task automatic set_req(input int i, input logic wen, input logic [7:0] addr,
                         input logic [3:0] be, input logic [31:0] wd, input logic [3:0] meta);
    bus.req_valid_i[i] = 1'b1; bus.req_wen_i[i] = wen; bus.req_addr_i[i] = addr;
    bus.req_be_i[i] = be; bus.req_wdata_i[i] = wd; bus.req_meta_i[i] = meta;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [3:0] valid;
    logic       rready;
    logic [3:0] exp_ready;
    logic       exp_rvalid;
  } vec_t;
  localparam int NumRows = 23;
  vec_t tbl [NumRows];

  typedef struct {
    int          idx;
    logic [3:0]  meta;
    logic [31:0] data;
    int          avail;
  } resp_t;
  resp_t outq [$];

  logic [3:0]  pend, p_wen;
  logic [7:0]  p_addr [4];
  logic [3:0]  p_be [4];
  logic [31:0] p_wd [4];
  logic [3:0]  p_meta [4];

  initial begin
    // All rows are reads from address 0 with meta = requester index.
    tbl[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b0};
    tbl[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b0};
    tbl[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1};
    tbl[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1};
    tbl[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1};
    tbl[5]  = '{4'b0000, 1'b1, 4'b0000, 1'b1};
    tbl[6]  = '{4'b0010, 1'b1, 4'b0010, 1'b1};
    tbl[7]  = '{4'b1010, 1'b1, 4'b1000, 1'b0};
    tbl[8]  = '{4'b0010, 1'b1, 4'b0010, 1'b1};
    tbl[9]  = '{4'b1010, 1'b1, 4'b1000, 1'b1};
    tbl[10] = '{4'b0010, 1'b1, 4'b0010, 1'b1};
    tbl[11] = '{4'b0000, 1'b1, 4'b0000, 1'b1};
    tbl[12] = '{4'b0000, 1'b1, 4'b0000, 1'b1};
    tbl[13] = '{4'b0000, 1'b1, 4'b0000, 1'b0};
    tbl[14] = '{4'b0001, 1'b0, 4'b0001, 1'b0};
    tbl[15] = '{4'b0001, 1'b0, 4'b0001, 1'b0};
    tbl[16] = '{4'b0001, 1'b0, 4'b0000, 1'b1};
    tbl[17] = '{4'b0001, 1'b0, 4'b0000, 1'b1};
    tbl[18] = '{4'b0001, 1'b1, 4'b0001, 1'b1};
    tbl[19] = '{4'b0001, 1'b1, 4'b0001, 1'b1};
    tbl[20] = '{4'b0000, 1'b1, 4'b0000, 1'b1};
    tbl[21] = '{4'b0000, 1'b1, 4'b0000, 1'b1};
    tbl[22] = '{4'b0000, 1'b1, 4'b0000, 1'b0};

    for (int i = 0; i < 256; i++) begin
      sram[i] = init_word(i);
      gold[i] = init_word(i);
    end

    // Reset state, with requests pending to show req_ready is forced low.
    idle_inputs();
    bus.req_valid_i = 4'b1111;
    bus.resp_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_req_ready", bus.req_ready_o, 0);
    chk("rst_bank_req", bus.bank_req_o, 0);
    chk("rst_bank_we", bus.bank_we_o, 0);
    chk("rst_resp_valid", bus.resp_valid_o, 0);
    idle_inputs();
    rst_n = 1'b1;

    // Arbitration and credit table.
    for (int r = 0; r < NumRows; r++) begin
      @(negedge clk);
      idle_inputs();
      for (int i = 0; i < 4; i++)
        if (tbl[r].valid[i]) set_req(i, 1'b0, 8'h00, 4'h0, 32'h0, 4'(i));
      bus.resp_ready_i = tbl[r].rready;
      #1;
      chk($sformatf("tbl[%0d].req_ready", r), bus.req_ready_o, tbl[r].exp_ready);
      chk($sformatf("tbl[%0d].bank_req", r), bus.bank_req_o, |tbl[r].exp_ready);
      chk($sformatf("tbl[%0d].resp_valid", r), bus.resp_valid_o, tbl[r].exp_rvalid);
    end

    // Full FIFO: reads stall, writes pass only without write acks.
    @(negedge clk);
    idle_inputs(); bus.resp_ready_i = 1'b0;
    set_req(0, 1'b0, 8'h00, 4'h0, 32'h0, 4'h0);
    #1 chk("full_rd0", bus.req_ready_o, 4'b0001);
    @(negedge clk);
    set_req(0, 1'b0, 8'h00, 4'h0, 32'h0, 4'h0);
    #1 chk("full_rd1", bus.req_ready_o, 4'b0001);
    @(negedge clk);
    idle_inputs();
    set_req(1, 1'b1, 8'h00, 4'h0, 32'h0, 4'h1);
`ifdef MEMPOOL_BANK_ARB_WRITE_ACK_EN
    #1 chk("full_wr", bus.req_ready_o, 4'b0000);
`else
    #1 chk("full_wr", bus.req_ready_o, 4'b0010);
`endif
    @(negedge clk);
    bus.resp_ready_i = 1'b1;
    #1 chk("full_wr_drain", bus.req_ready_o, 4'b0010);
    @(negedge clk);
    idle_inputs();
    repeat (6) @(negedge clk);

    // Single read, requester 2, addr 0x12, meta 5.
    set_req(2, 1'b0, 8'h12, 4'hF, 32'h0, 4'h5);
    #1;
    chk("rd_ready", bus.req_ready_o, 4'b0100);
    chk("rd_bank_req", bus.bank_req_o, 1);
    chk("rd_bank_we", bus.bank_we_o, 0);
    chk("rd_bank_addr", bus.bank_addr_o, 8'h12);
    @(negedge clk); idle_inputs();
    #1 chk("rd_lat1_valid", bus.resp_valid_o, 0);
    @(negedge clk);
    #1;
    chk("rd_resp_valid", bus.resp_valid_o, 1);
    chk("rd_resp_idx", bus.resp_idx_o, 2);
    chk("rd_resp_meta", bus.resp_meta_o, 4'h5);
    chk("rd_resp_data", bus.resp_rdata_o, 32'hA5A5_1234);

    // Partial write then read back.
    @(negedge clk);
    set_req(1, 1'b1, 8'h12, 4'b0011, 32'hDEAD_BEEF, 4'h3);
    #1;
    chk("wr_ready", bus.req_ready_o, 4'b0010);
    chk("wr_bank_we", bus.bank_we_o, 1);
    chk("wr_bank_be", bus.bank_be_o, 4'b0011);
    chk("wr_bank_wdata", bus.bank_wdata_o, 32'hDEAD_BEEF);
    @(negedge clk); idle_inputs();
    #1 chk("wr_lat1_valid", bus.resp_valid_o, 0);
    @(negedge clk);
`ifdef MEMPOOL_BANK_ARB_WRITE_ACK_EN
    #1;
    chk("wr_ack_valid", bus.resp_valid_o, 1);
    chk("wr_ack_idx", bus.resp_idx_o, 1);
    chk("wr_ack_meta", bus.resp_meta_o, 4'h3);
    chk("wr_ack_data", bus.resp_rdata_o, 0);
`else
    #1 chk("wr_no_resp", bus.resp_valid_o, 0);
`endif
    @(negedge clk);
    #1 chk("wr_after_valid", bus.resp_valid_o, 0);
    set_req(0, 1'b0, 8'h12, 4'hF, 32'h0, 4'h9);
    @(negedge clk); idle_inputs();
    @(negedge clk);
    #1;
    chk("rmw_valid", bus.resp_valid_o, 1);
    chk("rmw_data", bus.resp_rdata_o, 32'hA5A5_BEEF);

    // Reset the cycle after an accepted read.
    @(negedge clk);
    idle_inputs();
    set_req(2, 1'b0, 8'h12, 4'hF, 32'h0, 4'h7);
    #1 chk("rst_seq_ready", bus.req_ready_o, 4'b0100);
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    set_req(1, 1'b0, 8'h12, 4'hF, 32'h0, 4'h1);
    set_req(3, 1'b0, 8'h00, 4'hF, 32'h0, 4'hB);
    #1 chk("rst_seq_forced", bus.req_ready_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_seq_rr0", bus.req_ready_o, 4'b0010);
    chk("rst_seq_dropped", bus.resp_valid_o, 0);
    @(negedge clk);
    bus.req_valid_i[1] = 1'b0;
    #1;
    chk("rst_seq_next", bus.req_ready_o, 4'b1000);
    chk("rst_seq_dropped2", bus.resp_valid_o, 0);
    @(negedge clk); idle_inputs();
    #1;
    chk("rst_seq_r1_valid", bus.resp_valid_o, 1);
    chk("rst_seq_r1_idx", bus.resp_idx_o, 1);
    chk("rst_seq_r1_data", bus.resp_rdata_o, 32'hA5A5_BEEF);
    @(negedge clk);
    #1;
    chk("rst_seq_r3_idx", bus.resp_idx_o, 3);
    chk("rst_seq_r3_meta", bus.resp_meta_o, 4'hB);
    chk("rst_seq_r3_data", bus.resp_rdata_o, init_word(0));
    @(negedge clk);
    #1 chk("rst_seq_empty", bus.resp_valid_o, 0);

    // Randomized run against the reference model.
    do_reset();
    pend = '0;
    p_wen = '0;
    begin
      int rr = 0;
      for (int cyc = 0; cyc < 1500; cyc++) begin
        logic       exp_rv, pop, credit;
        int         win, occ;
        logic [3:0] exp_ready;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
          if (!pend[i] && $urandom_range(0, 99) < 55) begin
            pend[i]   = 1'b1;
            p_wen[i]  = ($urandom_range(0, 3) == 0);
            p_addr[i] = 8'h80 | 8'($urandom_range(0, 127));
            p_be[i]   = 4'($urandom);
            p_wd[i]   = $urandom;
            p_meta[i] = 4'($urandom);
          end
          bus.req_valid_i[i] = pend[i];
          bus.req_wen_i[i]   = p_wen[i];
          bus.req_addr_i[i]  = p_addr[i];
          bus.req_be_i[i]    = p_be[i];
          bus.req_wdata_i[i] = p_wd[i];
          bus.req_meta_i[i]  = p_meta[i];
        end
        if ((cyc / 64) % 2 == 1) bus.resp_ready_i = ($urandom_range(0, 3) == 0);
        else                     bus.resp_ready_i = ($urandom_range(0, 9) != 0);
        #1;
        exp_rv = (outq.size() > 0) && (outq[0].avail <= cyc);
        pop    = exp_rv && bus.resp_ready_i;
        occ    = outq.size() - (pop ? 1 : 0);
        credit = occ < int'(RespDepth);
        win    = -1;
        for (int k = 0; k < 4; k++) begin
          int j;
          j = (rr + k) % 4;
`ifdef MEMPOOL_BANK_ARB_WRITE_ACK_EN
          if (win < 0 && pend[j] && credit) win = j;
`else
          if (win < 0 && pend[j] && (p_wen[j] || credit)) win = j;
`endif
        end
        exp_ready = (win >= 0) ? 4'(1 << win) : 4'b0000;
        chk("rnd_req_ready", bus.req_ready_o, exp_ready);
        chk("rnd_bank_req", bus.bank_req_o, win >= 0);
        chk("rnd_resp_valid", bus.resp_valid_o, exp_rv);
        if (win >= 0) begin
          chk("rnd_bank_addr", bus.bank_addr_o, p_addr[win]);
          chk("rnd_bank_we", bus.bank_we_o, p_wen[win]);
          if (p_wen[win]) begin
            chk("rnd_bank_be", bus.bank_be_o, p_be[win]);
            chk("rnd_bank_wdata", bus.bank_wdata_o, p_wd[win]);
          end
        end
        if (exp_rv) begin
          chk("rnd_resp_idx", bus.resp_idx_o, outq[0].idx);
          chk("rnd_resp_meta", bus.resp_meta_o, outq[0].meta);
          chk("rnd_resp_data", bus.resp_rdata_o, outq[0].data);
        end
        if (pop) void'(outq.pop_front());
        if (win >= 0) begin
          if (p_wen[win]) begin
            for (int b = 0; b < 4; b++)
              if (p_be[win][b]) gold[p_addr[win]][8*b +: 8] = p_wd[win][8*b +: 8];
`ifdef MEMPOOL_BANK_ARB_WRITE_ACK_EN
            outq.push_back('{win, p_meta[win], 32'h0, cyc + 2});
`endif
          end else begin
            outq.push_back('{win, p_meta[win], gold[p_addr[win]], cyc + 2});
          end
          rr = (win + 1) % 4;
          pend[win] = 1'b0;
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mempool_bank_arbiter.md
# mempool_bank_arbiter

Round-robin arbiter and sequencer for one TCDM SRAM bank in a MemPool tile. Shares the bank's single request port between `NumReq` requesters (local cores plus remote-tile ports), drives the bank, and returns read data tagged with the requester index and the `reorder_id`/`core_id` metadata from `tcdm_payload_t`. A small response FIFO with credit-based admission decouples the fixed one-cycle SRAM latency from downstream backpressure.

## Interface
- `NumReq`, default 4: number of requesters, ≥2.
- `BankAddrWidth`, default 8: bank word address width (`TCDMAddrMemWidth`).
- `DataWidth`, default 32: data width; byte enable width is `DataWidth/8`.
- `MetaWidth`, default 4: opaque metadata width (`reorder_id` + `core_id`), returned unchanged.
- `RespDepth`, default 2: response FIFO depth, ≥1.
- `clk_i`  in  1: clock.
- `rst_ni`  in  1: synchronous active-low reset.
- `req_valid_i`  in  NumReq: per-requester request valid.
- `req_ready_o`  out  NumReq: per-requester accept, one-hot or zero.
- `req_addr_i`  in  NumReq×BankAddrWidth: word address.
- `req_wen_i`  in  NumReq: 1 = write.
- `req_be_i`  in  NumReq×DataWidth/8: byte enables.
- `req_wdata_i`  in  NumReq×DataWidth: write data.
- `req_meta_i`  in  NumReq×MetaWidth: metadata.
- `bank_req_o`  out  1: bank access this cycle.
- `bank_we_o`  out  1: bank write enable.
- `bank_addr_o`  out  BankAddrWidth: bank address.
- `bank_be_o`  out  DataWidth/8: bank byte enables.
- `bank_wdata_o`  out  DataWidth: bank write data.
- `bank_rdata_i`  in  DataWidth: read data, valid the cycle after `bank_req_o`.
- `resp_valid_o`  out  1: response valid.
- `resp_ready_i`  in  1: response accept.
- `resp_idx_o`  out  $clog2(NumReq): destination requester.
- `resp_rdata_o`  out  DataWidth: response data.
- `resp_meta_o`  out  MetaWidth: returned metadata.

## Operation
- Arbitration: pointer `rr_q` (reset 0). Winner = first `i` with `req_valid_i[i]` searching `rr_q, rr_q+1, …, NumReq-1, 0, …` (wrap-around). On grant `rr_q <= winner+1` mod `NumReq`; otherwise hold.
- Admission: grant only if `count + inflight - pop < RespDepth`, where `count` = FIFO occupancy, `inflight` = 1 if a response-producing access was issued last cycle, `pop` = `resp_valid_o & resp_ready_i`. Writes bypass the credit check unless `MEMPOOL_BANK_ARB_WRITE_ACK_EN` is defined.
- Grant: `req_ready_o[winner]=1`; bank outputs mux the winner's payload; `bank_req_o=1`, `bank_we_o=req_wen_i[winner]`.
- Issue of a read registers `{winner, meta}` into a one-entry in-flight stage; next cycle `bank_rdata_i` with that tag is pushed into the FIFO.
- FIFO: registered, in-order; head drives `resp_*`. Push and pop in the same cycle are allowed, including when full (pop frees the slot first).
- Requester rule: valid and payload held stable until ready; the arbiter never drops an accepted request.
- Idle: `bank_req_o=0`; bank data/address outputs are don't-care but driven to 0.

## Timing
- Reset values: `req_ready_o=0`, `bank_req_o=0`, `bank_we_o=0`, `resp_valid_o=0`; `rr_q=0`, FIFO empty, in-flight cleared. `req_ready_o` forced 0 while `rst_ni=0`.
- Read accepted in cycle t → `bank_req_o` in t → data sampled end of t+1 → `resp_valid_o` from t+2. Latency 2 cycles.
- Throughput: one access per cycle while credits remain; back-to-back reads sustain 1/cycle with `resp_ready_i=1` and `RespDepth≥2`.
- `req_ready_o` is combinational from `req_valid_i`, `rr_q`, credits and `resp_ready_i`; no dependency on `bank_rdata_i`.
- Reset mid-operation: in-flight read and FIFO contents discarded; no response emitted for them.
- Full FIFO with `resp_ready_i=0`: all reads stalled (`req_ready_o=0` for readers); writes still granted when macro undefined.

## Configuration
- `MEMPOOL_BANK_ARB_WRITE_ACK_EN`: defined → writes consume a credit and produce a response with `resp_rdata_o=0` and the request's metadata, at the same 2-cycle latency. Undefined → writes produce no response and need no credit.

## Test plan
- Single read, addr 0x12, meta 0x5, requester 2 → `bank_req_o` same cycle, `resp_valid_o` 2 cycles later with `resp_idx_o=2`, `resp_meta_o=0x5`, data = stored word.
- All 4 requesters valid continuously from reset → grants 0,1,2,3,0,… one per cycle; `rr_q` wraps 3→0.
- `resp_ready_i=0`, `RespDepth=2`, 4 back-to-back reads → exactly 2 accepted, then `req_ready_o=0`; raising `resp_ready_i` accepts the next read in that same cycle.
- Write of 0xDEADBEEF with be=4'b0011 then read same address → response low half 0xBEEF, upper bytes preserved; without macro no write response, with macro one response of data 0.
- Reset asserted the cycle after a read is accepted → no `resp_valid_o` after reset; `rr_q=0`; next request served normally.
- Requesters 1 and 3 valid, `rr_q=2` → requester 3 granted first, then 1.
